// File: rtl/twiddle_gen_pkg.sv
// Shared constants, FSM encoding and the elaboration-time cosine quantiser
// for the FFT twiddle generator.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package twiddle_gen_pkg;

  localparam int TG_DATA_WIDTH = `DATA_WIDTH;
  localparam int TG_LOG2_N_DEF = 5;
  localparam int TG_STAGE_W    = 4;
  localparam real TG_PI        = 3.14159265358979323846;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEQ  = 1'b1
  } tg_state_e;

  // Largest positive Q1.(dw-1) code; +1.0 saturates here.
  function automatic int q_max(input int dw);
    return (1 << (dw - 1)) - 1;
  endfunction

  // round(cos(2*pi*m/N) * 2^(dw-1)); only called for the first quarter wave,
  // so the value is never negative.
  function automatic int cos_q(input int m, input int log2n, input int dw);
    real ang;
    real v;
    int  r;
    ang = 2.0 * TG_PI * $itor(m) / $itor(1 << log2n);
    v   = $cos(ang) * $itor(1 << (dw - 1));
    r   = $rtoi(v + 0.5);
    if (r > q_max(dw)) r = q_max(dw);
    if (r < 0) r = 0;
    return r;
  endfunction

endpackage

// File: rtl/twiddle_quarter_rom.sv
// Quarter-wave cosine table (entries 0..N/4) with two registered read ports
// so the real and imaginary parts are fetched in the same cycle.
module twiddle_quarter_rom
  import twiddle_gen_pkg::*;
#(
  parameter int LOG2_N     = 5,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic [LOG2_N-2:0]     addr_a_i,
  input  logic [LOG2_N-2:0]     addr_b_i,
  output logic [DATA_WIDTH-1:0] data_a_o,
  output logic [DATA_WIDTH-1:0] data_b_o
);

  localparam int DEPTH = 1 << (LOG2_N - 1);
  localparam int QN    = 1 << (LOG2_N - 2);

  logic [DATA_WIDTH-1:0] tab [DEPTH];
  logic [DATA_WIDTH-1:0] data_a_q;
  logic [DATA_WIDTH-1:0] data_b_q;

  // Addresses above N/4 are never produced by the fold; they read zero.
  for (genvar m = 0; m < DEPTH; m++) begin : g_tab
    localparam int V = (m <= QN) ? cos_q(m, LOG2_N, DATA_WIDTH) : 0;
    assign tab[m] = V[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_a_q <= '0;
      data_b_q <= '0;
    end else if (en_i) begin
      data_a_q <= tab[addr_a_i];
      data_b_q <= tab[addr_b_i];
    end
  end

  assign data_a_o = data_a_q;
  assign data_b_o = data_b_q;

endmodule

// File: rtl/twiddle_gen.sv
// Radix-2 FFT twiddle generator: direct lookup or per-stage sequence,
// three-stage pipeline (fold, ROM read, sign) with a global stall.
module twiddle_gen
  import twiddle_gen_pkg::*;
#(
  parameter int DATA_WIDTH = TG_DATA_WIDTH,
  parameter int LOG2_N     = TG_LOG2_N_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_seq,
  input  logic                    req_inv,
  input  logic [LOG2_N-2:0]       req_addr,
  input  logic [TG_STAGE_W-1:0]   req_stage,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out_data,
  output logic [LOG2_N-2:0]       out_index,
  output logic                    out_last,
  output logic                    busy,
  output tg_state_e               dbg_state
);

  localparam int AW = LOG2_N - 1;
  localparam logic [AW-1:0] QN        = AW'(1 << (LOG2_N - 2));
  localparam logic [AW-1:0] LAST_I    = '1;
  localparam logic [TG_STAGE_W-1:0] MAX_STAGE = TG_STAGE_W'(LOG2_N - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Producers hold valid and payload until the transfer; ready never
  // depends on valid. The whole pipeline advances only when en is high.
  logic en;

  tg_state_e             state_q, state_d;
  logic [AW-1:0]         cnt_q, cnt_d;
  logic [TG_STAGE_W-1:0] stage_q, stage_d;
  logic                  inv_q, inv_d;

  logic                  issue;
  logic [AW-1:0]         iss_k;
  logic                  iss_inv;
  logic                  iss_last;
  logic [TG_STAGE_W-1:0] stage_clamp;
  logic [AW-1:0]         seq_mask;
  logic [TG_STAGE_W-1:0] seq_sh;

  logic                  k_le;
  logic [AW-1:0]         are_d, aim_d;

  logic                  v1_q, last1_q, nre1_q, nim1_q;
  logic [AW-1:0]         idx1_q, are1_q, aim1_q;
  logic                  v2_q, last2_q, nre2_q, nim2_q;
  logic [AW-1:0]         idx2_q;
  logic [DATA_WIDTH-1:0] rom_re, rom_im;
  logic [DATA_WIDTH-1:0] re_s, im_s;

  logic                    out_valid_q, out_last_q;
  logic [2*DATA_WIDTH-1:0] out_data_q;
  logic [AW-1:0]           out_index_q;

  assign en = !out_valid_q || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      stage_q <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      inv_q   <= inv_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stage_d     = stage_q;
    inv_d       = inv_q;
    req_ready   = 1'b0;
    issue       = 1'b0;
    iss_k       = '0;
    iss_inv     = 1'b0;
    iss_last    = 1'b0;
    stage_clamp = (req_stage > MAX_STAGE) ? MAX_STAGE : req_stage;
    // stage_q == AW wraps the shift to zero, giving an all-ones mask.
    seq_mask    = (AW'(1) << stage_q) - AW'(1);
    seq_sh      = TG_STAGE_W'(AW) - stage_q;
    case (state_q)
      ST_IDLE: begin
        req_ready = en && rst_n;
        if (req_valid && req_ready) begin
          if (req_seq) begin
            state_d = ST_SEQ;
            stage_d = stage_clamp;
            inv_d   = req_inv;
            cnt_d   = '0;
          end else begin
            issue    = 1'b1;
            iss_k    = req_addr;
            iss_inv  = req_inv;
            iss_last = 1'b1;
          end
        end
      end
      ST_SEQ: begin
        if (en) begin
          issue    = 1'b1;
          iss_k    = (cnt_q & seq_mask) << seq_sh;
          iss_inv  = inv_q;
          iss_last = (cnt_q == LAST_I);
          if (cnt_q == LAST_I) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Fold k onto the quarter wave. For k > N/4, N/2-k is taken modulo 2^AW,
  // which is exact because k is never zero on that branch.
  always_comb begin
    k_le  = (iss_k <= QN);
    are_d = k_le ? iss_k : (AW'(0) - iss_k);
    aim_d = k_le ? (QN - iss_k) : (iss_k - QN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      nre1_q  <= 1'b0;
      nim1_q  <= 1'b0;
      idx1_q  <= '0;
      are1_q  <= '0;
      aim1_q  <= '0;
    end else if (en) begin
      v1_q    <= issue;
      last1_q <= iss_last;
      nre1_q  <= !k_le;
      nim1_q  <= !iss_inv;
      idx1_q  <= iss_k;
      are1_q  <= are_d;
      aim1_q  <= aim_d;
    end
  end

  twiddle_quarter_rom #(
    .LOG2_N     (LOG2_N),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rom (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (en),
    .addr_a_i (are1_q),
    .addr_b_i (aim1_q),
    .data_a_o (rom_re),
    .data_b_o (rom_im)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q    <= 1'b0;
      last2_q <= 1'b0;
      nre2_q  <= 1'b0;
      nim2_q  <= 1'b0;
      idx2_q  <= '0;
    end else if (en) begin
      v2_q    <= v1_q;
      last2_q <= last1_q;
      nre2_q  <= nre1_q;
      nim2_q  <= nim1_q;
      idx2_q  <= idx1_q;
    end
  end

  always_comb begin
    re_s = nre2_q ? -rom_re : rom_re;
    im_s = nim2_q ? -rom_im : rom_im;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
    end else if (en) begin
      out_valid_q <= v2_q;
      out_last_q  <= last2_q;
      out_data_q  <= {re_s, im_s};
      out_index_q <= idx2_q;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign busy      = (state_q == ST_SEQ) || v1_q || v2_q || out_valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_twiddle_gen.sv
// Directed bench for twiddle_gen (DATA_WIDTH=16, LOG2_N=5) with
// hand-computed twiddle words and immediate assertions.
module tb_twiddle_gen;
  import twiddle_gen_pkg::*;

  localparam int DW = 16;
  localparam int AW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_seq = 1'b0;
  logic            req_inv = 1'b0;
  logic [AW-1:0]   req_addr = '0;
  logic [3:0]      req_stage = '0;
  logic            out_ready = 1'b1;
  logic            req_ready, out_valid, out_last, busy;
  logic [2*DW-1:0] out_data;
  logic [AW-1:0]   out_index;
  tg_state_e       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] w_tab [16];
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];

  always #5 clk = ~clk;

  twiddle_gen #(.DATA_WIDTH(DW), .LOG2_N(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_seq   (req_seq),
    .req_inv   (req_inv),
    .req_addr  (req_addr),
    .req_stage (req_stage),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(output int cnt, input int limit);
    cnt = 0;
    #1;
    while (!req_ready && cnt < limit) begin
      @(negedge clk); #1;
      cnt++;
    end
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check({tag, "_quiet"}, 64'(seen), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  task automatic direct_check(input string tag, input logic [3:0] k, input logic inv,
                              input logic [31:0] exp_data);
    int cnt;
    @(negedge clk);
    req_valid = 1'b1; req_seq = 1'b0; req_addr = k; req_inv = inv;
    wait_ready(cnt, 50);
    check({tag, "_rdy"}, 64'(req_ready), 64'(1));
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 4'($urandom_range(0, 15));
    req_inv   = 1'($urandom_range(0, 1));
    #1 check({tag, "_lat1"}, 64'(out_valid), 64'(0));
    @(negedge clk); #1 check({tag, "_lat2"}, 64'(out_valid), 64'(0));
    @(negedge clk); #1
    check({tag, "_word"}, 64'({out_valid, out_last, out_index, out_data}),
          64'({1'b1, 1'b1, k, exp_data}));
  endtask

  task automatic seq_run(input string tag, input logic [3:0] stage, input int eff_stage,
                         input bit rand_rdy, input bit follow);
    int n_words, got, guard, wcnt, kk, gap;
    bit started, early_rdy;
    logic [63:0] obs, exp;
    exp_q.delete();
    got_q.delete();
    for (int i = 0; i < 16; i++) begin
      kk = (i % (1 << eff_stage)) << (4 - eff_stage);
      exp_q.push_back(64'({w_tab[kk], 4'(kk), (i == 15)}));
    end
    if (follow) exp_q.push_back(64'({w_tab[4], 4'd4, 1'b1}));
    n_words = exp_q.size();
    got = 0; started = 1'b0; early_rdy = 1'b0; gap = -1;
    fork
      begin
        @(negedge clk);
        req_valid = 1'b1; req_seq = 1'b1; req_stage = stage; req_inv = 1'b0;
        wait_ready(wcnt, 50);
        @(negedge clk);
        started = 1'b1;
        if (follow) begin
          req_seq = 1'b0; req_addr = 4'd4; req_inv = 1'b0;
          wait_ready(gap, 100);
          @(negedge clk);
        end
        req_valid = 1'b0;
        req_stage = 4'($urandom_range(0, 15));
        req_inv   = 1'b1;
      end
      begin
        guard = 0;
        while (got < n_words && guard < 600) begin
          @(negedge clk);
          out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
          #1;
          if (started && got < 13 && req_ready) early_rdy = 1'b1;
          if (out_valid && out_ready) begin
            got_q.push_back(64'({out_data, out_index, out_last}));
            got++;
          end
          guard++;
        end
        out_ready = 1'b1;
      end
    join
    check({tag, "_count"}, 64'(got_q.size()), 64'(n_words));
    for (int i = 0; i < n_words; i++) begin
      exp = exp_q.pop_front();
      obs = (got_q.size() > 0) ? got_q.pop_front() : 64'hx;
      check($sformatf("%s_w%0d", tag, i), obs, exp);
    end
    if (follow) check({tag, "_b2b_gap"}, 64'(gap), 64'(16));
    else        check({tag, "_rdy_low"}, 64'(early_rdy), 64'(0));
    expect_quiet(tag, 5);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cnt, got;
    w_tab[0]  = 32'h7FFF_0000; w_tab[1]  = 32'h7D8A_E707;
    w_tab[2]  = 32'h7642_CF04; w_tab[3]  = 32'h6A6E_B8E3;
    w_tab[4]  = 32'h5A82_A57E; w_tab[5]  = 32'h471D_9592;
    w_tab[6]  = 32'h30FC_89BE; w_tab[7]  = 32'h18F9_8276;
    w_tab[8]  = 32'h0000_8001; w_tab[9]  = 32'hE707_8276;
    w_tab[10] = 32'hCF04_89BE; w_tab[11] = 32'hB8E3_9592;
    w_tab[12] = 32'hA57E_A57E; w_tab[13] = 32'h9592_B8E3;
    w_tab[14] = 32'h89BE_CF04; w_tab[15] = 32'h8276_E707;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_out", 64'({out_data, out_index, out_last}), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rel_req_ready", 64'(req_ready), 64'(1));

    // Direct lookups
    direct_check("dir_k0", 4'd0, 1'b0, 32'h7FFF_0000);
    direct_check("dir_k2", 4'd2, 1'b0, 32'h7642_CF04);
    direct_check("dir_k8", 4'd8, 1'b0, 32'h0000_8001);
    direct_check("dir_k12", 4'd12, 1'b0, 32'hA57E_A57E);
    direct_check("dir_k2_inv", 4'd2, 1'b1, 32'h7642_30FC);
    direct_check("dir_k8_inv", 4'd8, 1'b1, 32'h0000_7FFF);
    expect_quiet("dir", 4);

    // Sequences
    seq_run("seq_s4", 4'd4, 4, 1'b0, 1'b0);
    seq_run("seq_s1", 4'd1, 1, 1'b0, 1'b0);
    seq_run("seq_s0_b2b", 4'd0, 0, 1'b0, 1'b1);
    seq_run("seq_s4_stall", 4'd4, 4, 1'b1, 1'b0);
    seq_run("seq_s9", 4'd9, 4, 1'b0, 1'b0);

    // Reset in the middle of a sequence
    @(negedge clk);
    req_valid = 1'b1; req_seq = 1'b1; req_stage = 4'd4; req_inv = 1'b0;
    wait_ready(cnt, 50);
    @(negedge clk);
    req_valid = 1'b0;
    got = 0; cnt = 0;
    #1;
    while (got < 7 && cnt < 100) begin
      if (out_valid) got++;
      if (got < 7) begin
        @(negedge clk); #1;
      end
      cnt++;
    end
    check("mid_words_before_rst", 64'(got), 64'(7));
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_req_ready", 64'(req_ready), 64'(0));
    check("mid_rst_out", 64'({out_data, out_index, out_last}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rel_req_ready", 64'(req_ready), 64'(1));
    check("mid_rel_state", 64'(dbg_state), 64'(ST_IDLE));
    direct_check("post_rst_k1", 4'd1, 1'b0, 32'h7D8A_E707);
    expect_quiet("post_rst", 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
